// File: rtl/freq_gen_nco_if.sv
// rtl/freq_gen_nco_if.sv - control/status bundle of the NCO frequency generator
//
// Purpose: groups the retune request, run control and generator outputs of
// freq_gen_nco so that producer and consumer connect through one port.
// Signals:
//    FREQ_KHZ_I    requested frequency in kHz, sampled with FREQ_LOAD_I
//    FREQ_LOAD_I   one-cycle retune request
//    ENABLE_I      run accumulator; low clears phase
//    BUSY_O        tuning word computation in progress
//    CLAMP_O       last accepted request was clamped to SYS_KHZ/2
//    TUNE_WORD_O   tuning word in use
//    CLK_EN_O      one-cycle strobe per generated period
//    SQ_O          square wave (accumulator MSB)
//    PERIOD_CNT_O  strobes counted in the last completed window
// Modports: master drives requests, slave is the generator.
interface freq_gen_nco_if #(
   parameter int ACC_WIDTH  = 32,
   parameter int FREQ_WIDTH = 20
);
   logic [FREQ_WIDTH-1:0] FREQ_KHZ_I;
   logic                  FREQ_LOAD_I;
   logic                  ENABLE_I;
   logic                  BUSY_O;
   logic                  CLAMP_O;
   logic [ACC_WIDTH-1:0]  TUNE_WORD_O;
   logic                  CLK_EN_O;
   logic                  SQ_O;
   logic [31:0]           PERIOD_CNT_O;

   modport master (
      output FREQ_KHZ_I, FREQ_LOAD_I, ENABLE_I,
      input  BUSY_O, CLAMP_O, TUNE_WORD_O, CLK_EN_O, SQ_O, PERIOD_CNT_O
   );

   modport slave (
      input  FREQ_KHZ_I, FREQ_LOAD_I, ENABLE_I,
      output BUSY_O, CLAMP_O, TUNE_WORD_O, CLK_EN_O, SQ_O, PERIOD_CNT_O
   );
endinterface

// File: rtl/freq_gen_nco.sv
// rtl/freq_gen_nco.sv - programmable NCO frequency generator with self-count
//
// Purpose: converts a requested frequency in kHz into a tuning word
// floor(f * 2^ACC_WIDTH / SYS_KHZ) with a bit-serial restoring divider, then
// runs a phase accumulator producing a one-cycle strobe and a square wave.
// Strobes are counted per window of WIN_CYCLES clocks for cross-checking.
// Ports:
//    SYS_CLK_I   single clock, rising edge
//    SYS_RSTN_I  synchronous active-low reset
//    bus         freq_gen_nco_if slave modport (request, control, outputs)
module freq_gen_nco #(
   parameter int SYS_PRD_NS = 10,
   parameter int ACC_WIDTH  = 32,
   parameter int FREQ_WIDTH = 20,
   parameter int WIN_CYCLES = 1000000000 / SYS_PRD_NS
) (
   input  logic          SYS_CLK_I,
   input  logic          SYS_RSTN_I,
   freq_gen_nco_if.slave bus
);

   localparam int SYS_KHZ  = 1000000 / SYS_PRD_NS;
   localparam int HALF_KHZ = SYS_KHZ / 2;
   // One spare bit above SYS_KHZ so the doubled remainder never overflows.
   localparam int REM_W    = $clog2(SYS_KHZ) + 1;
   localparam int CNT_W    = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
   localparam int WIN_W    = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

   localparam logic [REM_W-1:0] SYS_KHZ_R = REM_W'(SYS_KHZ);
   localparam logic [31:0]      HALF_32   = 32'(HALF_KHZ);
   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_APPLY
   } state_t;

   state_t               state_q,   state_d;
   logic                 busy_q,    busy_d;
   logic                 clamp_q,   clamp_d;
   logic [REM_W-1:0]     rem_q,     rem_d;
   logic [ACC_WIDTH-1:0] quo_q,     quo_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [ACC_WIDTH-1:0] tune_q,    tune_d;
   logic [ACC_WIDTH-1:0] acc_q,     acc_d;
   logic                 clk_en_q,  clk_en_d;
   logic                 sq_q,      sq_d;
   logic [WIN_W-1:0]     win_q,     win_d;
   logic [31:0]          strobe_q,  strobe_d;
   logic [31:0]          period_q,  period_d;

   logic [31:0]          freq_ext;
   logic [REM_W-1:0]     f_clamped;
   logic [REM_W-1:0]     rem_x2;
   logic                 quo_bit;
   logic [ACC_WIDTH:0]   acc_sum;
   logic [31:0]          strobe_inc;

   // Request clamped to Nyquist so the tuning word never exceeds 2^(ACC_WIDTH-1).
   always_comb begin
      freq_ext  = 32'(bus.FREQ_KHZ_I);
      f_clamped = (freq_ext > HALF_32) ? REM_W'(HALF_KHZ) : REM_W'(freq_ext);
   end

   // Restoring division step. rem is always below SYS_KHZ, so its top bit is
   // zero and dropping it in the shift loses nothing.
   always_comb begin
      rem_x2  = {rem_q[REM_W-2:0], 1'b0};
      quo_bit = (rem_x2 >= SYS_KHZ_R);
   end

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      clamp_d   = clamp_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      bit_cnt_d = bit_cnt_q;
      tune_d    = tune_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.FREQ_LOAD_I) begin
               clamp_d   = (freq_ext > HALF_32);
               rem_d     = f_clamped;
               quo_d     = '0;
               bit_cnt_d = CNT_W'(ACC_WIDTH - 1);
               busy_d    = 1'b1;
               state_d   = ST_DIV;
            end
         end
         ST_DIV: begin
            rem_d = quo_bit ? (rem_x2 - SYS_KHZ_R) : rem_x2;
            quo_d = {quo_q[ACC_WIDTH-2:0], quo_bit};
            if (bit_cnt_q == '0) begin
               state_d = ST_APPLY;
            end else begin
               bit_cnt_d = bit_cnt_q - 1'b1;
            end
         end
         ST_APPLY: begin
            // Accumulator is left alone so the frequency change is phase-continuous.
            tune_d  = quo_q;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Phase accumulator: the carry out of the add is the period strobe.
   always_comb begin
      acc_sum = {1'b0, acc_q} + {1'b0, tune_q};
      if (bus.ENABLE_I) begin
         acc_d    = acc_sum[ACC_WIDTH-1:0];
         clk_en_d = acc_sum[ACC_WIDTH];
         // A zero word freezes the phase; keep the square wave low rather than
         // holding whatever MSB the last retune left behind.
         sq_d     = (tune_q != '0) && acc_q[ACC_WIDTH-1];
      end else begin
         acc_d    = '0;
         clk_en_d = 1'b0;
         sq_d     = 1'b0;
      end
   end

   // Self-count window. A strobe in the terminal cycle closes out with that window.
   always_comb begin
      strobe_inc = (clk_en_q && (strobe_q != 32'hFFFF_FFFF)) ? strobe_q + 32'd1 : strobe_q;
      win_d      = win_q;
      strobe_d   = strobe_inc;
      period_d   = period_q;
      if (win_q == WIN_LAST) begin
         win_d    = '0;
         strobe_d = '0;
         period_d = strobe_inc;
      end else begin
         win_d = win_q + 1'b1;
      end
   end

   always_ff @(posedge SYS_CLK_I) begin
      if (!SYS_RSTN_I) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         clamp_q   <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         bit_cnt_q <= '0;
         tune_q    <= '0;
         acc_q     <= '0;
         clk_en_q  <= 1'b0;
         sq_q      <= 1'b0;
         win_q     <= '0;
         strobe_q  <= '0;
         period_q  <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         clamp_q   <= clamp_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         bit_cnt_q <= bit_cnt_d;
         tune_q    <= tune_d;
         acc_q     <= acc_d;
         clk_en_q  <= clk_en_d;
         sq_q      <= sq_d;
         win_q     <= win_d;
         strobe_q  <= strobe_d;
         period_q  <= period_d;
      end
   end

   assign bus.BUSY_O       = busy_q;
   assign bus.CLAMP_O      = clamp_q;
   assign bus.TUNE_WORD_O  = tune_q;
   assign bus.CLK_EN_O     = clk_en_q;
   assign bus.SQ_O         = sq_q;
   assign bus.PERIOD_CNT_O = period_q;

endmodule

// File: tb/tb_freq_gen_nco.sv
// tb/tb_freq_gen_nco.sv - scoreboard bench for freq_gen_nco
module tb_freq_gen_nco;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   always #5 clk = ~clk;

   freq_gen_nco_if #(.ACC_WIDTH(32), .FREQ_WIDTH(20)) bus_if ();

   freq_gen_nco #(
      .SYS_PRD_NS (10),
      .ACC_WIDTH  (32),
      .FREQ_WIDTH (20),
      .WIN_CYCLES (10000)
   ) dut (
      .SYS_CLK_I  (clk),
      .SYS_RSTN_I (rstn),
      .bus        (bus_if)
   );

   typedef struct {
      string       name;
      logic [31:0] word;
      logic        clamp;
   } exp_t;

   exp_t sb_q[$];
   int   checks     = 0;
   int   errors     = 0;
   logic abort_tune = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a tuning result is presented when BUSY_O falls.
   initial begin : monitor
      logic busy_prev;
      int   busy_len;
      exp_t e;
      busy_prev = 1'b0;
      busy_len  = 0;
      forever begin
         @(negedge clk);
         if (bus_if.BUSY_O) begin
            busy_len++;
         end else if (busy_prev) begin
            if (!abort_tune) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  check({e.name, "_word"}, bus_if.TUNE_WORD_O, e.word);
                  check({e.name, "_clamp"}, bus_if.CLAMP_O, e.clamp);
                  check({e.name, "_busy_len"}, busy_len, 33);
               end
            end
            busy_len = 0;
         end
         busy_prev = bus_if.BUSY_O;
      end
   end

   task automatic pulse_load(input logic [19:0] f);
      bus_if.FREQ_KHZ_I  = f;
      bus_if.FREQ_LOAD_I = 1'b1;
      @(negedge clk);
      bus_if.FREQ_LOAD_I = 1'b0;
   endtask

   task automatic expect_load(input string name, input logic [19:0] f,
                              input logic [31:0] word, input logic clamp);
      exp_t e;
      e.name  = name;
      e.word  = word;
      e.clamp = clamp;
      sb_q.push_back(e);
      pulse_load(f);
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (bus_if.BUSY_O && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) check("busy_timeout", 1, 0);
      @(negedge clk);
   endtask

   task automatic strobe_gaps(input string name, input int n, input int exp_gap);
      int gap;
      int w;
      w = 0;
      while (!bus_if.CLK_EN_O && w < 64) begin
         @(negedge clk);
         w++;
      end
      if (w >= 64) begin
         check({name, "_first_timeout"}, 1, 0);
      end else begin
         for (int k = 0; k < n; k++) begin
            gap = 0;
            do begin
               @(negedge clk);
               gap++;
            end while (!bus_if.CLK_EN_O && gap < 64);
            check(name, gap, exp_gap);
         end
      end
   endtask

   initial begin : stimulus
      logic sq_s[8];
      int   bad;
      int   ones;
      int   first;
      int   strobes;

      bus_if.FREQ_KHZ_I  = '0;
      bus_if.FREQ_LOAD_I = 1'b0;
      bus_if.ENABLE_I    = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_busy",   bus_if.BUSY_O,       0);
      check("rst_clamp",  bus_if.CLAMP_O,      0);
      check("rst_word",   bus_if.TUNE_WORD_O,  0);
      check("rst_clk_en", bus_if.CLK_EN_O,     0);
      check("rst_sq",     bus_if.SQ_O,         0);
      check("rst_period", bus_if.PERIOD_CNT_O, 0);

      // Window count at 1 MHz; load and enable sampled on the first edge after reset.
      rstn            = 1'b1;
      bus_if.ENABLE_I = 1'b1;
      expect_load("f1000", 20'd1000, 32'd42949672, 1'b0);
      repeat (9998) @(negedge clk);
      check("period_before_win", bus_if.PERIOD_CNT_O, 0);
      @(negedge clk);
      check("period_win1", bus_if.PERIOD_CNT_O, 99);
      repeat (10000) @(negedge clk);
      check("period_win2", bus_if.PERIOD_CNT_O, 100);

      // Reset in the middle of a division discards it.
      abort_tune = 1'b1;
      pulse_load(20'd25000);
      repeat (5) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("abort_busy",   bus_if.BUSY_O,       0);
      check("abort_word",   bus_if.TUNE_WORD_O,  0);
      check("abort_clk_en", bus_if.CLK_EN_O,     0);
      check("abort_period", bus_if.PERIOD_CNT_O, 0);
      rstn = 1'b1;
      @(negedge clk);
      abort_tune = 1'b0;

      // 25 MHz: strobe every 4, square 2 high / 2 low.
      expect_load("f25000", 20'd25000, 32'h4000_0000, 1'b0);
      wait_idle();
      repeat (6) @(negedge clk);
      strobe_gaps("gap_25000", 3, 4);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         sq_s[i] = bus_if.SQ_O;
      end
      bad  = 0;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(sq_s[i]);
      for (int i = 0; i < 6; i++) if (sq_s[i] == sq_s[i+2]) bad++;
      check("sq_ones", ones, 4);
      check("sq_alternate", bad, 0);

      // Load during BUSY ignored; fresh load afterwards accepted.
      expect_load("f25000_again", 20'd25000, 32'h4000_0000, 1'b0);
      repeat (4) @(negedge clk);
      pulse_load(20'd10000);
      wait_idle();
      expect_load("f10000", 20'd10000, 32'h1999_9999, 1'b0);
      wait_idle();
      repeat (12) @(negedge clk);
      strobe_gaps("gap_10000", 3, 10);

      // Clamp above Nyquist, then exactly Nyquist.
      expect_load("f60000", 20'd60000, 32'h8000_0000, 1'b1);
      wait_idle();
      repeat (4) @(negedge clk);
      strobe_gaps("gap_clamped", 3, 2);
      expect_load("f50000", 20'd50000, 32'h8000_0000, 1'b0);
      wait_idle();

      // Enable low for 3 cycles, re-enable restarts phase at 0.
      expect_load("f25000_en", 20'd25000, 32'h4000_0000, 1'b0);
      wait_idle();
      repeat (3) @(negedge clk);
      bus_if.ENABLE_I = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus_if.CLK_EN_O || bus_if.SQ_O) bad++;
      end
      check("disabled_quiet", bad, 0);
      bus_if.ENABLE_I = 1'b1;
      first = 0;
      for (int i = 1; i <= 10 && first == 0; i++) begin
         @(negedge clk);
         if (bus_if.CLK_EN_O) first = i;
      end
      check("reenable_first_strobe", first, 4);

      // Zero frequency: no strobes, square held low, window count 0.
      expect_load("f0", 20'd0, 32'h0, 1'b0);
      wait_idle();
      repeat (2) @(negedge clk);
      strobes = 0;
      bad     = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (bus_if.CLK_EN_O) strobes++;
         if (bus_if.SQ_O) bad++;
      end
      check("zero_strobes", strobes, 0);
      check("zero_sq", bad, 0);
      check("zero_period", bus_if.PERIOD_CNT_O, 0);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
